// File: rtl/knn_topk.sv
// Keeps the K nearest (distance, label) pairs in a sorted register list and
// streams them out nearest-first on request, then empties for the next point.
module knn_topk #(
  parameter int  K  = 4,
  parameter int  DW = 33,
  parameter int  LW = 8,
  localparam int CW = $clog2(K + 1),
  localparam int IW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dist_in,
  input  logic [LW-1:0] label_in,
  input  logic          drain,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_dist,
  output logic [LW-1:0] out_label,
  output logic          out_last,
  output logic          done,
  output logic [CW-1:0] count
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [K-1:0]  occ_q, occ_d, occ_ins, lt, lt_prev, prev_occ;
  logic [DW-1:0] dist_q [K];
  logic [LW-1:0] label_q [K];
  logic [DW-1:0] prev_dist [K];
  logic [LW-1:0] prev_label [K];
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;
  logic          ins;

  // Shift source for each slot: slot 0 takes the candidate, others their neighbour.
  for (genvar g = 0; g < K; g++) begin : g_slot
    if (g == 0) begin : g_head
      assign prev_dist[g]  = dist_in;
      assign prev_label[g] = label_in;
      assign prev_occ[g]   = 1'b1;
    end else begin : g_tail
      assign prev_dist[g]  = dist_q[g-1];
      assign prev_label[g] = label_q[g-1];
      assign prev_occ[g]   = occ_q[g-1];
    end
  end

  always_comb begin
    lt      = '0;
    occ_ins = occ_q;
    for (int i = 0; i < K; i++) begin
      lt[i] = !occ_q[i] || (dist_in < dist_q[i]);
    end
    lt_prev = lt << 1;
    for (int i = 0; i < K; i++) begin
      if (lt[i]) occ_ins[i] = lt_prev[i] ? prev_occ[i] : 1'b1;
    end
  end

  assign in_ready  = (state_q == FILL) && !rst;
  assign ins       = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign count     = count_q;
  assign out_last  = out_valid_q && (CW'(rd_idx_q) == count_q - CW'(1));
  assign out_dist  = out_valid_q ? dist_q[rd_idx_q]  : '0;
  assign out_label = out_valid_q ? label_q[rd_idx_q] : '0;

  always_comb begin
    state_d     = state_q;
    occ_d       = occ_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      FILL: begin
        if (ins) begin
          occ_d = occ_ins;
          if (count_q < CW'(K)) count_d = count_q + CW'(1);
        end
        // A same-cycle insert makes the list non-empty before the drain starts.
        if (drain) begin
          if (count_q != '0 || ins) begin
            state_d     = DRAIN;
            rd_idx_d    = '0;
            out_valid_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            state_d     = FILL;
            occ_d       = '0;
            count_d     = '0;
            rd_idx_d    = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      occ_q       <= '0;
      count_q     <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      if (ins && lt[i]) begin
        dist_q[i]  <= lt_prev[i] ? prev_dist[i]  : dist_in;
        label_q[i] <= lt_prev[i] ? prev_label[i] : label_in;
      end
    end
  end

endmodule

// File: doc/knn_topk.md
# knn_topk

Maintains the K smallest distances, each with its label, seen since the last clear, in a sorted register list. It sits directly downstream of the distance calculator in the KNN datapath and consumes its unsigned W+1-bit squared-distance results one per cycle. On request it streams the sorted list out, nearest first, over a valid/ready handshake, then empties itself for the next test point.

## Interface
- K, 4: number of neighbours kept (K ≥ 1)
- DW, 33: distance width, unsigned, matches distance-calculator output
- LW, 8: label width
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  dist_in/label_in valid this cycle
- in_ready  output  1  block accepts input (high only in FILL)
- dist_in  input  DW  candidate squared distance
- label_in  input  LW  candidate label
- drain  input  1  single-cycle request to stream out the list
- out_valid  output  1  out_dist/out_label valid
- out_ready  input  1  consumer accepts current beat
- out_dist  output  DW  streamed distance
- out_label  output  LW  streamed label
- out_last  output  1  current beat is the final entry
- done  output  1  one-cycle pulse: drain complete, list cleared
- count  output  $clog2(K+1)  number of occupied slots

## Operation
- Storage: slots 0..K-1 of {occ, dist, label}. Occupied slots are contiguous from slot 0 and sorted ascending, so slot 0 holds the smallest distance.
- Insertion takes one cycle and happens in FILL when in_valid && in_ready. It is a parallel shift-insert. Per slot i, with lt_i = !occ[i] || (dist_in < dist[i]) (unsigned, strict):
  - lt_i && (i==0 || !lt_{i-1}): slot i loads the candidate.
  - lt_i && lt_{i-1}: slot i loads slot i-1.
  - otherwise: slot i holds.
- Ties: a candidate equal to a stored distance goes after it, so order is stable by arrival.
- Full list (count==K) with dist_in ≥ dist[K-1]: the candidate is discarded; no change.
- Full list with a smaller candidate: the slot K-1 entry is dropped and count stays K.
- count increments by 1 on an accepted insert when count<K and saturates at K.
- FSM states:
  - FILL: in_ready=1. If drain=1 and count>0, go to DRAIN with rd_idx=0. If drain=1 and count==0, pulse done next cycle and stay in FILL.
  - DRAIN: in_ready=0. out_valid=1. out_dist/out_label = slot[rd_idx]. out_last = (rd_idx==count-1).
    - On out_valid && out_ready && !out_last: rd_idx++.
    - On the out_last beat being accepted: clear all occ bits, set count=0, pulse done, return to FILL.
- A drain pulse while in DRAIN is ignored.
- in_valid is ignored while in DRAIN, because in_ready=0.
- If in_valid and drain are both high in FILL, the insert is performed that cycle and the drain sees the updated list. The first out beat includes the new entry.
- Outputs hold steady while out_valid && !out_ready.

## Timing
- Reset values (asynchronous, take effect immediately): state=FILL, all occ=0, count=0, rd_idx=0, out_valid=0, out_last=0, done=0, out_dist=0, out_label=0. in_ready=1 once rst deasserts.
- Insert latency: an entry accepted at edge n is reflected in the slots and count after edge n. Sustained throughput is 1 insert per clock.
- Drain latency: drain sampled at edge n gives out_valid=1 after edge n. With out_ready held high, the block streams count beats on consecutive cycles.
- done is high for exactly the one cycle after the final handshake, or after the cycle in which drain was sampled when the list is empty. in_ready=1 in that same cycle.
- rst asserted mid-DRAIN aborts the stream at once: out_valid drops and the list is emptied. There is no done pulse.
- All outputs are registered except in_ready, out_last and out_dist/out_label, which are decoded from registered state and the slot mux.

## Test plan
- Ordering: K=4. Insert 50/A, 10/B, 30/C, 20/D, then drain with out_ready=1. Required: beats 10/B, 20/D, 30/C, 50/A; out_last only on 50/A; done next cycle; count=0.
- Overflow and discard: after the list holds 10,20,30,50, insert 60 → list unchanged, count=4. Insert 15 → list 10,15,20,30 (50 dropped). Insert 30/E → discarded, because it is not strictly less than 30.
- Ties and stability: insert 7/X, 7/Y, 7/Z. Drain → X, Y, Z in that order.
- Backpressure: drain a 3-entry list with out_ready toggling 0,1,0,0,1,1. Required: each beat held stable while out_ready=0; exactly 3 handshakes; done one cycle after the third; in_ready=0 throughout DRAIN.
- Edge events:
  - drain with count=0 → no out_valid, done pulse the next cycle.
  - in_valid with 5 together with drain, list holding 8 → drain emits 5, then 8.
  - in_valid during DRAIN → ignored.
- Reset mid-drain: assert rst asynchronously (between edges) after the first beat of a 4-entry drain. Required: out_valid=0 and count=0 immediately, no done pulse. After rst deasserts, in_ready=1 and a new insert of 9 drains as the single beat 9 with out_last=1.
